cache_policy_controller_multi: RTL
==================================

CACHE_POLICY_CONTROLLER_MULTI -- requirements
Module: cache_policy_controller_multi

Interface
REQ-001 SHALL have parameter BW_ACCESS_ADDR, default 32, width of access_addr_i.
REQ-002 SHALL have parameter N_CAPACITY_BLOCKS, default 64, total cache blocks (power of two).
REQ-003 SHALL have parameter N_WORDS_PER_BLOCK, default 4, words per block (power of two).
REQ-004 SHALL have parameter ASSOCIATIVITY, default 4, ways per set (power of two, 2..N_CAPACITY_BLOCKS).
REQ-005 SHALL have parameter POLICY, default 0, replacement mode: 0 = FIFO, 1 = tree pseudo-LRU, 2 = LFSR random.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-007 SHALL have derived widths BW_CAPACITY_BLOCKS = clog2(N_CAPACITY_BLOCKS), BW_WAY = clog2(ASSOCIATIVITY), BW_SET = clog2(N_CAPACITY_BLOCKS/ASSOCIATIVITY), BW_WORDS_PER_BLOCK = clog2(N_WORDS_PER_BLOCK).
REQ-008 clock_i  input  1  sole clock; all state updates on rising edge.
REQ-009 reset_i  input  1  asynchronous, active-high reset.
REQ-010 access_addr_i  input  BW_ACCESS_ADDR  word address of the current access; set index = access_addr_i[BW_WORDS_PER_BLOCK +: BW_SET].
REQ-011 cache_addr_i  input  BW_CAPACITY_BLOCKS  block address of a hit, format {way, set}.
REQ-012 miss_i  input  1  single-cycle request for a replacement address.
REQ-013 hit_i  input  1  single-cycle request to update policy state for cache_addr_i.
REQ-014 done_o  output  1  one-cycle pulse marking addr_o valid.
REQ-015 addr_o  output  BW_CAPACITY_BLOCKS  replacement address {victim_way, set}; set field absent when BW_SET = 0.

Function
REQ-016 On miss_i sampled high, addr_o and done_o SHALL update at the next rising edge (latency 1); done_o SHALL be high for exactly that one cycle unless miss_i is high again.
REQ-017 addr_o SHALL hold its last value until the next miss; done_o SHALL be low in every cycle not following a miss.
REQ-018 Back-to-back misses on consecutive cycles SHALL each be serviced, giving done_o high continuously and a new addr_o each cycle.
REQ-019 FIFO: per set a BW_WAY-bit counter; victim = counter; counter increments on miss, wrapping ASSOCIATIVITY-1 -> 0; hits SHALL NOT change it.
REQ-020 PLRU: per set ASSOCIATIVITY-1 tree bits, node 0 = root, children of node n at 2n+1 / 2n+2; victim walk goes left on 0, right on 1.
REQ-021 PLRU touch of way w SHALL set every node on w's path to point away from w; a miss SHALL touch the victim way it returns; a hit SHALL touch way cache_addr_i[BW_CAPACITY_BLOCKS-1 -: BW_WAY] in set cache_addr_i[BW_SET-1:0].
REQ-022 RANDOM: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, SHALL advance every cycle out of reset; victim = LFSR[BW_WAY-1:0] at the sampling edge; hits SHALL NOT change state.
REQ-023 When miss_i and hit_i are high in the same cycle, the miss SHALL be serviced and the hit SHALL be discarded.
REQ-024 When ASSOCIATIVITY = N_CAPACITY_BLOCKS, a single set SHALL be used and addr_o SHALL equal the victim way.
REQ-025 Policy-state storage of unused modes SHALL NOT be instantiated.

Reset
REQ-026 Asserting reset_i SHALL immediately force done_o = 0, addr_o = 0, all FIFO counters = 0, all PLRU bits = 0, LFSR = LFSR_SEED, statistics counters = 0.
REQ-027 A miss or hit coincident with, or pending at, reset assertion SHALL be dropped; the first edge after deassertion SHALL service requests normally.

Configuration
REQ-028 With macro CACHE_POLICY_STATS_EN defined, the block SHALL add outputs hit_count_o and miss_count_o (32 bits each) counting serviced hits and misses, saturating at 32'hFFFFFFFF; a discarded hit (REQ-023) SHALL NOT count.
REQ-029 Without CACHE_POLICY_STATS_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-030 POLICY=0, 64 blocks, 4-way, 4 words: 5 misses to access_addr_i=0x0 -> addr_o = 0x00,0x10,0x20,0x30,0x00, done_o high each following cycle.
REQ-031 POLICY=1, same geometry: reset, miss set 0 -> way 0; miss -> way 2; miss -> way 1; hit cache_addr_i=0x30 (way 3); miss -> way 3 not returned, returns way 3 only after ways 0..2 are touched again.
REQ-032 POLICY=1: miss_i and hit_i high together on set 5 -> addr_o = {victim,5}, hit ignored, hit_count_o unchanged with CACHE_POLICY_STATS_EN.
REQ-033 POLICY=2: reset then miss at first edge -> addr_o way = 0xACE1 & 3 = way 1; sequence repeatable across resets.
REQ-034 Fully associative (ASSOCIATIVITY=64, POLICY=0): 65 misses -> addr_o 0..63 then 0.
REQ-035 Assert reset_i mid-burst of misses -> done_o and addr_o drop to 0 asynchronously; next miss after release returns way 0 (FIFO/PLRU).

Source files
------------

// File: rtl/cache_policy_controller_multi_if.sv
// rtl/cache_policy_controller_multi_if.sv - request/response bundle for the replacement-policy controller
// Statistics outputs exist only when CACHE_POLICY_STATS_EN is defined.
interface cache_policy_controller_multi_if #(
    parameter int BW_ACCESS_ADDR     = 32,
    parameter int BW_CAPACITY_BLOCKS = 6
);
    logic [BW_ACCESS_ADDR-1:0]     access_addr_i;
    logic [BW_CAPACITY_BLOCKS-1:0] cache_addr_i;
    logic                          miss_i;
    logic                          hit_i;
    logic                          done_o;
    logic [BW_CAPACITY_BLOCKS-1:0] addr_o;
`ifdef CACHE_POLICY_STATS_EN
    logic [31:0]                   hit_count_o;
    logic [31:0]                   miss_count_o;

    modport master (
        output access_addr_i, cache_addr_i, miss_i, hit_i,
        input  done_o, addr_o, hit_count_o, miss_count_o
    );
    modport slave (
        input  access_addr_i, cache_addr_i, miss_i, hit_i,
        output done_o, addr_o, hit_count_o, miss_count_o
    );
`else
    modport master (
        output access_addr_i, cache_addr_i, miss_i, hit_i,
        input  done_o, addr_o
    );
    modport slave (
        input  access_addr_i, cache_addr_i, miss_i, hit_i,
        output done_o, addr_o
    );
`endif
endinterface

// File: rtl/cache_policy_controller_multi.sv
// rtl/cache_policy_controller_multi.sv - set-associative replacement victim selector (FIFO / tree PLRU / LFSR random)
// Optional hit/miss statistics counters are enabled with macro CACHE_POLICY_STATS_EN.
module cache_policy_controller_multi #(
    parameter int          BW_ACCESS_ADDR    = 32,
    parameter int          N_CAPACITY_BLOCKS = 64,
    parameter int          N_WORDS_PER_BLOCK = 4,
    parameter int          ASSOCIATIVITY     = 4,
    parameter int          POLICY            = 0,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    cache_policy_controller_multi_if.slave bus
);
    localparam int BW_CAPACITY_BLOCKS = $clog2(N_CAPACITY_BLOCKS);
    localparam int BW_WAY             = $clog2(ASSOCIATIVITY);
    localparam int BW_SET             = $clog2(N_CAPACITY_BLOCKS / ASSOCIATIVITY);
    localparam int BW_WORDS_PER_BLOCK = $clog2(N_WORDS_PER_BLOCK);
    localparam int N_SETS             = N_CAPACITY_BLOCKS / ASSOCIATIVITY;
    localparam int BW_SET_IDX         = (BW_SET > 0) ? BW_SET : 1;
    localparam int N_NODES            = ASSOCIATIVITY - 1;

    logic [BW_SET_IDX-1:0]         miss_set;
    logic [BW_SET_IDX-1:0]         hit_set;
    logic [BW_WAY-1:0]             hit_way;
    logic [BW_WAY-1:0]             victim_way;
    logic [BW_CAPACITY_BLOCKS-1:0] next_addr;
    logic                          miss_fire;
    logic                          hit_fire;
    logic                          unused_inputs;

    // A hit arriving together with a miss is dropped; the miss wins.
    assign miss_fire = bus.miss_i;
    assign hit_fire  = bus.hit_i & ~bus.miss_i;
    assign hit_way   = bus.cache_addr_i[BW_CAPACITY_BLOCKS-1 -: BW_WAY];

    generate
        if (BW_SET > 0) begin : g_sets
            assign miss_set  = bus.access_addr_i[BW_WORDS_PER_BLOCK +: BW_SET];
            assign hit_set   = bus.cache_addr_i[BW_SET-1:0];
            assign next_addr = {victim_way, miss_set};
        end else begin : g_one_set
            assign miss_set  = '0;
            assign hit_set   = '0;
            assign next_addr = victim_way;
        end
    endgenerate

    assign unused_inputs = ^{bus.access_addr_i, bus.cache_addr_i, hit_fire, hit_set, hit_way};

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bus.done_o <= 1'b0;
            bus.addr_o <= '0;
        end else begin
            bus.done_o <= miss_fire;
            if (miss_fire) begin
                bus.addr_o <= next_addr;
            end
        end
    end

    generate
        if (POLICY == 1) begin : g_plru
            logic [N_NODES-1:0] plru_tree [N_SETS];
            logic [N_NODES-1:0] tree_miss;
            logic [N_NODES-1:0] tree_hit;
            logic [BW_WAY-1:0]  plru_victim;

            // Walking the victim path and pointing each node away is a toggle of that node.
            always_comb begin
                logic [BW_WAY-1:0] node;
                logic              b;
                tree_miss   = plru_tree[miss_set];
                plru_victim = '0;
                node        = '0;
                b           = 1'b0;
                for (int lvl = 0; lvl < BW_WAY; lvl++) begin
                    b                           = tree_miss[node];
                    plru_victim[BW_WAY-1-lvl]   = b;
                    tree_miss[node]             = ~b;
                    node = BW_WAY'(2 * 32'(node) + 1 + 32'(b));
                end
            end

            always_comb begin
                logic [BW_WAY-1:0] node;
                logic              b;
                tree_hit = plru_tree[hit_set];
                node     = '0;
                b        = 1'b0;
                for (int lvl = 0; lvl < BW_WAY; lvl++) begin
                    b              = hit_way[BW_WAY-1-lvl];
                    tree_hit[node] = ~b;
                    node = BW_WAY'(2 * 32'(node) + 1 + 32'(b));
                end
            end

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    for (int s = 0; s < N_SETS; s++) begin
                        plru_tree[s] <= '0;
                    end
                end else if (miss_fire) begin
                    plru_tree[miss_set] <= tree_miss;
                end else if (hit_fire) begin
                    plru_tree[hit_set] <= tree_hit;
                end
            end

            assign victim_way = plru_victim;
        end else if (POLICY == 2) begin : g_random
            logic [15:0] lfsr;

            // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    lfsr <= LFSR_SEED;
                end else begin
                    lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                end
            end

            assign victim_way = lfsr[BW_WAY-1:0];
        end else begin : g_fifo
            logic [BW_WAY-1:0] fifo_cnt [N_SETS];

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    for (int s = 0; s < N_SETS; s++) begin
                        fifo_cnt[s] <= '0;
                    end
                end else if (miss_fire) begin
                    fifo_cnt[miss_set] <= fifo_cnt[miss_set] + BW_WAY'(1);
                end
            end

            assign victim_way = fifo_cnt[miss_set];
        end
    endgenerate

`ifdef CACHE_POLICY_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_fire && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_fire && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign bus.hit_count_o  = hit_cnt;
    assign bus.miss_count_o = miss_cnt;
`endif
endmodule
